// File: rtl/seg7_pkg.sv
// Shared constants for the seg7_scan display block: digit count, IO half-word
// addresses and the active-low segment patterns {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned NDIG = 8;

  localparam logic [1:0] SEG_ADDR_LO = 2'b00;
  localparam logic [1:0] SEG_ADDR_HI = 2'b10;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index n holds the pattern for hex digit n; dp (bit 7) is always off.
  localparam logic [15:0][7:0] SEG_PAT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-nibble to active-low 7-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  assign seg = SEG_PAT[hex];

endmodule

// File: rtl/seg7_scan.sv
// Memory-mapped 8-digit multiplexed 7-segment display driver.
// Define SEG7_BLANK_LEADING_ZERO_EN to blank digits above the top nonzero nibble.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned NDIG     = seg7_pkg::NDIG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  segwrite,
  input  logic                  segcs,
  input  logic [1:0]            segaddr,
  input  logic [15:0]           segwdata,
  output logic [NDIG-1:0]       seg_en,
  output logic [7:0]            seg_out,
  output logic [4*NDIG-1:0]     segvalue
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = $clog2(NDIG);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [4*NDIG-1:0] word_q;
  logic [PW-1:0]     presc_q;
  logic [IW-1:0]     idx_q;
  logic [3:0]        nibble;
  logic [7:0]        dec_seg;
  logic [7:0]        digit_seg;

  assign segvalue = word_q;
  assign nibble   = word_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

`ifdef SEG7_BLANK_LEADING_ZERO_EN
  logic [IW-1:0] msd;

  // Highest nonzero nibble; digit 0 is never blanked so a zero word shows "0".
  always_comb begin
    msd = '0;
    for (int i = 1; i < int'(NDIG); i++) begin
      if (word_q[4*i +: 4] != 4'h0) msd = IW'(i);
    end
  end

  assign digit_seg = (idx_q > msd) ? SEG_BLANK : dec_seg;
`else
  assign digit_seg = dec_seg;
`endif

  // Writes only touch word_q, so the scan timing is never disturbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else if (segcs && segwrite) begin
      case (segaddr)
        SEG_ADDR_LO: word_q[15:0]  <= segwdata;
        SEG_ADDR_HI: word_q[31:16] <= segwdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_q <= '0;
      idx_q   <= idx_q + IW'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_en  <= '1;
      seg_out <= SEG_BLANK;
    end else begin
      seg_en  <= ~(NDIG'(1) << idx_q);
      seg_out <= digit_seg;
    end
  end

endmodule
